// File: rtl/vadd_pkg.sv
// vadd_pkg: register offsets, command opcodes and sequencer states
// shared by the vector-add controller files.
package vadd_pkg;

    localparam logic [15:0] REG_START  = 16'h0000;
    localparam logic [15:0] REG_A_BASE = 16'h0004;
    localparam logic [15:0] REG_B_BASE = 16'h0008;
    localparam logic [15:0] REG_C_BASE = 16'h000C;
    localparam logic [15:0] REG_LEN    = 16'h0010;
    localparam logic [15:0] REG_STATUS = 16'h0014;
    localparam logic [15:0] REG_PERF   = 16'h0018;

    localparam logic [31:0] BASE_MASK  = 32'hFFFF_FFE0;
    localparam int          BEAT_SHIFT = 5;

    localparam logic [1:0] RD_A = 2'd0;
    localparam logic [1:0] RD_B = 2'd1;
    localparam logic [1:0] WR_C = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        ISSUE_B,
        ISSUE_C,
        WAIT_CPL,
        DONE
    } state_t;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = strb[i] ? data[i*8 +: 8]
                                  : old[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/vadd_ctrl_regs.sv
// vadd_ctrl_regs: AXI-Lite slave and register file for the
// vector-add controller (one write and one read in flight).
module vadd_ctrl_regs
    import vadd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [15:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [15:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    input  logic        busy,
    input  logic        done_set,
    input  logic        err_set,
    input  logic [31:0] perf_cnt,
    output logic        start,
    output logic [31:0] a_base,
    output logic [31:0] b_base,
    output logic [31:0] c_base,
    output logic [31:0] len,
    output logic        done,
    output logic        err
);

    logic        wr_fire;
    logic        rd_fire;
    logic        st_wr;
    logic        clr_done;
    logic        clr_err;
    logic [31:0] rd_mux;

    assign s_awready = s_awvalid & s_wvalid & ~s_bvalid;
    assign s_wready  = s_awready;
    assign wr_fire   = s_awready;
    assign s_arready = s_arvalid & ~s_rvalid;
    assign rd_fire   = s_arready;
    assign s_bresp   = 2'b00;
    assign s_rresp   = 2'b00;

    assign start    = wr_fire && (s_awaddr == REG_START);
    assign st_wr    = wr_fire && (s_awaddr == REG_STATUS);
    assign clr_done = st_wr & s_wstrb[0] & s_wdata[1];
    assign clr_err  = st_wr & s_wstrb[0] & s_wdata[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_base <= '0;
            b_base <= '0;
            c_base <= '0;
            len    <= '0;
        end else if (wr_fire) begin
            unique case (1'b1)
                s_awaddr == REG_A_BASE:
                    a_base <= apply_strb(a_base, s_wdata, s_wstrb)
                              & BASE_MASK;
                s_awaddr == REG_B_BASE:
                    b_base <= apply_strb(b_base, s_wdata, s_wstrb)
                              & BASE_MASK;
                s_awaddr == REG_C_BASE:
                    c_base <= apply_strb(c_base, s_wdata, s_wstrb)
                              & BASE_MASK;
                s_awaddr == REG_LEN:
                    len <= apply_strb(len, s_wdata, s_wstrb);
                default: ;
            endcase
        end
    end

    // A hardware set wins over a same-cycle software clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (done_set)
                done <= 1'b1;
            else if (start || clr_done)
                done <= 1'b0;
            if (err_set)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s_bvalid <= 1'b0;
        else if (wr_fire)
            s_bvalid <= 1'b1;
        else if (s_bready)
            s_bvalid <= 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            s_araddr == REG_A_BASE: rd_mux = a_base;
            s_araddr == REG_B_BASE: rd_mux = b_base;
            s_araddr == REG_C_BASE: rd_mux = c_base;
            s_araddr == REG_LEN:    rd_mux = len;
            s_araddr == REG_STATUS:
                rd_mux = {29'd0, err, done, busy};
            s_araddr == REG_PERF:   rd_mux = perf_cnt;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
        end else if (rd_fire) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_mux;
        end else if (s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/vadd_ctrl.sv
// vadd_ctrl: command sequencer for the vector-add accelerator.
// Optional cycle counter at 0x18 under VADD_CTRL_PERF_CNT_EN.
module vadd_ctrl
    import vadd_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int MAX_BURST  = 16,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [15:0]           s_awaddr,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [15:0]           s_araddr,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_op,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_beats,
    input  logic                  wr_done,
    output logic                  irq
);

    localparam int          OW    = $clog2(MAX_OUT + 1);
    localparam logic [31:0] FPB   = 32'(DATA_WIDTH / 32);
    localparam logic [31:0] BURST = 32'(MAX_BURST);
    localparam logic [OW-1:0] CAP = OW'(MAX_OUT);
    localparam int          PADW  = ADDR_WIDTH - 32;

    state_t                state;
    state_t                state_nx;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  done_set;
    logic                  err_set;
    logic [31:0]           perf_cnt;
    logic [31:0]           a_base;
    logic [31:0]           b_base;
    logic [31:0]           c_base;
    logic [31:0]           len;
    logic [31:0]           a_lat;
    logic [31:0]           b_lat;
    logic [31:0]           c_lat;
    logic [31:0]           remaining;
    logic [31:0]           total_beats;
    logic [7:0]            chunk;
    logic [ADDR_WIDTH-1:0] offset;
    logic [OW-1:0]         outstanding;
    logic                  go;
    logic                  at_cap;
    logic                  wr_acc;
    logic                  cpl;

    vadd_ctrl_regs u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bresp   (s_bresp),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .busy      (busy),
        .done_set  (done_set),
        .err_set   (err_set),
        .perf_cnt  (perf_cnt),
        .start     (start),
        .a_base    (a_base),
        .b_base    (b_base),
        .c_base    (c_base),
        .len       (len),
        .done      (done),
        .err       (err)
    );

    // Ceiling division without the LEN+FPB-1 overflow near 2^32.
    assign total_beats = len / FPB + {31'd0, |(len % FPB)};
    assign chunk  = (remaining > BURST) ? 8'(MAX_BURST)
                                        : remaining[7:0];
    assign busy   = (state != IDLE);
    assign go     = start && (state == IDLE);
    assign at_cap = (outstanding == CAP);
    assign wr_acc = (state == ISSUE_C) && cmd_ready;
    assign cpl    = wr_done && (outstanding != '0);

    assign done_set = (state == DONE);
    assign err_set  = (start && busy)
                   || (wr_done && outstanding == '0);
    assign irq      = done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_valid = 1'b0;
        cmd_op    = RD_A;
        cmd_addr  = '0;
        cmd_beats = '0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (total_beats == '0) ? DONE
                                                   : ISSUE_A;
            end
            ISSUE_A: begin
                if (!at_cap) begin
                    cmd_valid = 1'b1;
                    cmd_op    = RD_A;
                    cmd_addr  = {{PADW{1'b0}}, a_lat} + offset;
                    cmd_beats = chunk;
                    if (cmd_ready)
                        state_nx = ISSUE_B;
                end
            end
            ISSUE_B: begin
                cmd_valid = 1'b1;
                cmd_op    = RD_B;
                cmd_addr  = {{PADW{1'b0}}, b_lat} + offset;
                cmd_beats = chunk;
                if (cmd_ready)
                    state_nx = ISSUE_C;
            end
            ISSUE_C: begin
                cmd_valid = 1'b1;
                cmd_op    = WR_C;
                cmd_addr  = {{PADW{1'b0}}, c_lat} + offset;
                cmd_beats = chunk;
                if (cmd_ready)
                    state_nx = (remaining > {24'd0, chunk})
                             ? ISSUE_A : WAIT_CPL;
            end
            WAIT_CPL: begin
                if (outstanding == '0)
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat     <= '0;
            b_lat     <= '0;
            c_lat     <= '0;
            remaining <= '0;
            offset    <= '0;
        end else if (go) begin
            a_lat     <= a_base;
            b_lat     <= b_base;
            c_lat     <= c_base;
            remaining <= total_beats;
            offset    <= '0;
        end else if (wr_acc) begin
            remaining <= remaining - {24'd0, chunk};
            offset    <= offset
                       + (ADDR_WIDTH'(chunk) << BEAT_SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            outstanding <= '0;
        else if (wr_acc && !cpl)
            outstanding <= outstanding + OW'(1);
        else if (!wr_acc && cpl)
            outstanding <= outstanding - OW'(1);
    end

`ifdef VADD_CTRL_PERF_CNT_EN
    logic [31:0] cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycles <= '0;
        else if (go)
            cycles <= '0;
        else if (busy && state != DONE && cycles != '1)
            cycles <= cycles + 32'd1;
    end

    assign perf_cnt = cycles;
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_vadd_ctrl.sv
// tb_vadd_ctrl: randomized bench for vadd_ctrl with a
// job-level command model and a memory-engine responder.
module tb_vadd_ctrl;

    typedef struct packed {
        logic [1:0]  op;
        logic [63:0] addr;
        logic [7:0]  beats;
    } cmd_t;

    localparam logic [15:0] A_START  = 16'h00;
    localparam logic [15:0] A_ABASE  = 16'h04;
    localparam logic [15:0] A_BBASE  = 16'h08;
    localparam logic [15:0] A_CBASE  = 16'h0C;
    localparam logic [15:0] A_LEN    = 16'h10;
    localparam logic [15:0] A_STATUS = 16'h14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_awvalid, s_awready;
    logic [15:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [15:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_addr;
    logic [7:0]  cmd_beats;
    logic        wr_done;
    logic        irq;

    cmd_t got_q[$];
    cmd_t exp_q[$];
    int   errs = 0;
    int   checks = 0;
    int   pending = 0;
    int   cap_viol = 0;
    int   n_wrc = 0;
    int   rel = 0;
    bit   hold = 0;
    bit   spur = 0;
    bit   rdy_always = 0;

    always #5 clk = ~clk;

    vadd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bresp   (s_bresp),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_beats (cmd_beats),
        .wr_done   (wr_done),
        .irq       (irq)
    );

    task automatic chk(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] op,
                                input logic [63:0] addr,
                                input logic [7:0] beats);
        cmd_t c;
        c.op = op;
        c.addr = addr;
        c.beats = beats;
        return c;
    endfunction

    // Job model: 8 floats per 32-byte beat, bursts of up to 16.
    task automatic build_exp(input logic [31:0] len,
                             input logic [31:0] a,
                             input logic [31:0] b,
                             input logic [31:0] c);
        logic [63:0] beats, off, ch, ab, bb, cb;
        exp_q.delete();
        beats = (64'(len) + 64'd7) / 64'd8;
        ab = {32'd0, a & 32'hFFFF_FFE0};
        bb = {32'd0, b & 32'hFFFF_FFE0};
        cb = {32'd0, c & 32'hFFFF_FFE0};
        off = 0;
        while (beats > 0) begin
            ch = (beats > 16) ? 64'd16 : beats;
            exp_q.push_back(mk(2'd0, ab + off, 8'(ch)));
            exp_q.push_back(mk(2'd1, bb + off, 8'(ch)));
            exp_q.push_back(mk(2'd2, cb + off, 8'(ch)));
            off += ch * 32;
            beats -= ch;
        end
    endtask

    // Memory engine: random ready, completions for past WR_C only.
    initial begin
        cmd_ready = 1'b0;
        wr_done = 1'b0;
        forever begin
            @(negedge clk);
            wr_done = 1'b0;
            if (!rst_n) begin
                cmd_ready = 1'b0;
                pending = 0;
                continue;
            end
            if (spur) begin
                wr_done = 1'b1;
                spur = 0;
            end else if (pending > 0 && hold && rel > 0) begin
                wr_done = 1'b1;
                pending--;
                rel--;
            end else if (pending > 0 && !hold
                         && $urandom_range(0, 2) == 0) begin
                wr_done = 1'b1;
                pending--;
            end
            cmd_ready = rdy_always ? 1'b1
                      : ($urandom_range(0, 3) != 0);
            #1;
            if (cmd_valid && cmd_ready) begin
                got_q.push_back(mk(cmd_op, cmd_addr, cmd_beats));
                if (cmd_op == 2'd2) begin
                    n_wrc++;
                    pending++;
                    if (pending > 4)
                        cap_viol++;
                end
            end
        end
    end

    task automatic axi_wr(input logic [15:0] ad,
                          input logic [31:0] d,
                          input logic [3:0]  st);
        bit ok;
        ok = 0;
        @(negedge clk);
        s_awaddr = ad;
        s_wdata = d;
        s_wstrb = st;
        s_awvalid = 1'b1;
        s_wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (s_awready && s_wready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        if (!ok)
            chk("aw handshake", 0, 1);
        else
            chk("bresp", {s_bvalid, s_bresp}, 3'b100);
    endtask

    task automatic axi_rd(input logic [15:0] ad,
                          output logic [31:0] d);
        bit ok;
        ok = 0;
        d = 'x;
        @(negedge clk);
        s_araddr = ad;
        s_arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (s_arready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        s_arvalid = 1'b0;
        if (ok && s_rvalid)
            d = s_rdata;
        else
            chk("rd handshake", 0, 1);
    endtask

    task automatic start_job(input logic [31:0] len,
                             input logic [31:0] a,
                             input logic [31:0] b,
                             input logic [31:0] c);
        axi_wr(A_ABASE, a, 4'hF);
        axi_wr(A_BBASE, b, 4'hF);
        axi_wr(A_CBASE, c, 4'hF);
        axi_wr(A_LEN, len, 4'hF);
        build_exp(len, a, b, c);
        got_q.delete();
        n_wrc = 0;
        cap_viol = 0;
        axi_wr(A_START, 32'd1, 4'hF);
    endtask

    task automatic finish_job(input string tag,
                              input logic [31:0] exp_st);
        logic [31:0] d;
        int n;
        n = 0;
        while (!irq && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " irq"}, irq, 1);
        chk({tag, " ncmd"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s cmd%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, " cap"}, cap_viol, 0);
        axi_rd(A_STATUS, d);
        chk({tag, " status"}, d, exp_st);
        axi_wr(A_STATUS, 32'h6, 4'hF);
        chk({tag, " irq clr"}, irq, 0);
        axi_rd(A_STATUS, d);
        chk({tag, " status clr"}, d, 0);
    endtask

    task automatic wait_wrc(input int n);
        for (int i = 0; i < 400 && n_wrc < n; i++)
            @(negedge clk);
        chk("wrc reached", n_wrc >= n, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [31:0] ln;
        rst_n = 1'b0;
        s_awvalid = 1'b0;
        s_awaddr = '0;
        s_wvalid = 1'b0;
        s_wdata = '0;
        s_wstrb = '0;
        s_bready = 1'b1;
        s_arvalid = 1'b0;
        s_araddr = '0;
        s_rready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst outs", {cmd_valid, irq, s_bvalid, s_rvalid},
            4'b0000);
        rst_n = 1'b1;
        axi_rd(A_STATUS, d);
        chk("rst status", d, 0);
        axi_rd(A_ABASE, d);
        chk("rst abase", d, 0);

        axi_wr(A_ABASE, 32'hDEAD_BEEF, 4'hF);
        axi_rd(A_ABASE, d);
        chk("abase mask", d, 32'hDEAD_BEE0);
        axi_wr(A_LEN, 32'h1234_5678, 4'b0010);
        axi_rd(A_LEN, d);
        chk("len strb", d, 32'h0000_5600);
        axi_wr(16'h0040, 32'hFFFF_FFFF, 4'hF);
        axi_rd(16'h0040, d);
        chk("unmapped", d, 0);
        axi_rd(A_START, d);
        chk("start rd", d, 0);

        start_job(32'd64, 32'h0, 32'h100, 32'h200);
        finish_job("single", 32'h2);

        hold = 1;
        start_job(32'd300, 32'h0, 32'h1000, 32'h2000);
        wait_wrc(3);
        repeat (10) @(negedge clk);
        chk("multi irq early", irq, 0);
        rel = 2;
        repeat (10) @(negedge clk);
        chk("multi irq 2of3", irq, 0);
        hold = 0;
        finish_job("multi", 32'h2);

        start_job(32'd0, 32'h40, 32'h80, 32'hC0);
        for (int i = 0; i < 2 && !irq; i++)
            @(negedge clk);
        chk("zero irq", irq, 1);
        finish_job("zero", 32'h2);

        hold = 1;
        rdy_always = 1;
        start_job(32'd768, 32'h1_0000, 32'h2_0000, 32'h3_0000);
        repeat (60) @(negedge clk);
        #2;
        chk("cap wrc", n_wrc, 4);
        chk("cap valid", cmd_valid, 0);
        rel = 1;
        repeat (20) @(negedge clk);
        #2;
        chk("cap release", n_wrc, 5);
        chk("cap valid2", cmd_valid, 0);
        hold = 0;
        rdy_always = 0;
        finish_job("cap", 32'h2);

        hold = 1;
        start_job(32'd300, $urandom, $urandom, $urandom);
        wait_wrc(3);
        axi_wr(A_ABASE, 32'h5555_0000, 4'hF);
        axi_wr(A_START, 32'd1, 4'hF);
        axi_rd(A_STATUS, d);
        chk("busy err", d, 32'h5);
        hold = 0;
        finish_job("err", 32'h6);

        spur = 1;
        repeat (4) @(negedge clk);
        axi_rd(A_STATUS, d);
        chk("spur err", d, 32'h4);
        axi_wr(A_STATUS, 32'h4, 4'h1);
        axi_rd(A_STATUS, d);
        chk("spur clr", d, 0);

        for (int j = 0; j < 8; j++) begin
            ln = $urandom_range(0, 700);
            start_job(ln, $urandom, $urandom, $urandom);
            finish_job($sformatf("rnd%0d", j), 32'h2);
        end

        hold = 1;
        start_job(32'd300, 32'h100, 32'h200, 32'h300);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (cmd_valid && cmd_op == 2'd1)
                break;
        end
        chk("mid op B", {cmd_valid, cmd_op}, 3'b101);
        rst_n = 1'b0;
        #1;
        chk("mid rst outs", {cmd_valid, irq}, 2'b00);
        repeat (3) @(negedge clk);
        hold = 0;
        rst_n = 1'b1;
        axi_rd(A_ABASE, d);
        chk("mid abase", d, 0);
        axi_rd(A_BBASE, d);
        chk("mid bbase", d, 0);
        axi_rd(A_CBASE, d);
        chk("mid cbase", d, 0);
        axi_rd(A_LEN, d);
        chk("mid len", d, 0);
        axi_rd(A_STATUS, d);
        chk("mid status", d, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
